// File: rtl/epu_layer_seq.sv
// Layer sequencer: walks a descriptor list in SRAM, starts one layer engine
// per descriptor, waits for its finish, clears it and flips the ping-pong
// activation buffer when asked. Watchdog, list-length and engine-id errors
// park the sequencer with a sticky error code.
module epu_layer_seq #(
    parameter int N_ENG       = 4,
    parameter int MAX_LAYERS  = 64,
    parameter int TIMEOUT_CYC = 1 << 20
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_start_i,
    input  logic [9:0]       cmd_base_i,
    input  logic             abort_i,
    output logic             desc_cs_o,
    output logic [9:0]       desc_addr_o,
    input  logic [31:0]      desc_rdata_i,
    output logic [N_ENG-1:0] eng_start_o,
    input  logic [N_ENG-1:0] eng_finish_i,
    output logic [N_ENG-1:0] eng_clr_o,
    output logic             buf_sel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [6:0]       layer_cnt_o
);

    localparam int              WD_W     = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LIM   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [6:0]      MAX_L    = 7'(MAX_LAYERS);
    localparam logic [2:0]      N_ENG_L  = 3'(N_ENG);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      ptr_q, ptr_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            buf_q, buf_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic            clr_all_q, clr_all_d;
    logic            dec_first_q;

    // descriptor fields, captured once per layer
    logic [1:0]      id_q;
    logic            last_q;
    logic            swap_q;

    logic            dec_first;
    logic [1:0]      cur_id;
    logic [3:0]      fin_ext;
    logic [3:0]      oh_id;
    logic            unused_bits;

    // On the first DECODE cycle the fields are still only on the SRAM bus.
    assign dec_first   = (state_q == S_DECODE) && dec_first_q;
    assign cur_id      = dec_first ? desc_rdata_i[1:0] : id_q;
    assign oh_id       = 4'b0001 << id_q;
    assign unused_bits = ^{desc_rdata_i[31:4], oh_id};

    // Widen finish to the 2-bit id space so out-of-range ids read as 0.
    always_comb begin
        fin_ext = '0;
        fin_ext[N_ENG-1:0] = eng_finish_i;
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            wd_q        <= '0;
            cnt_q       <= '0;
            buf_q       <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= '0;
            clr_all_q   <= 1'b0;
            dec_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wd_q        <= wd_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            err_q       <= err_d;
            code_q      <= code_d;
            clr_all_q   <= clr_all_d;
            dec_first_q <= (state_q == S_FETCH);
        end
    end

    // Latch descriptor fields on the first DECODE cycle only.
    always_ff @(posedge clk) begin
        if (dec_first) begin
            id_q   <= desc_rdata_i[1:0];
            last_q <= desc_rdata_i[2];
            swap_q <= desc_rdata_i[3];
        end
    end

    // Next-state logic; abort wins over every other transition.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        err_d     = err_q;
        code_d    = code_q;
        clr_all_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_start_i) begin
                    ptr_d   = cmd_base_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                    buf_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if ({1'b0, cur_id} >= N_ENG_L) begin
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                    state_d = S_ERR;
                end else if (!fin_ext[cur_id]) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (fin_ext[id_q]) begin
                    state_d = S_NEXT;
                end else if (wd_d == WD_LIM) begin
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                    state_d = S_ERR;
                end
            end
            S_NEXT: begin
                cnt_d = cnt_q + 7'd1;
                if (swap_q) begin
                    buf_d = ~buf_q;
                end
                if (last_q) begin
                    state_d = S_DONE;
                end else if (cnt_d == MAX_L) begin
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                    state_d = S_ERR;
                end else begin
                    ptr_d   = ptr_q + 10'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            ptr_d     = ptr_q;
            wd_d      = wd_q;
            cnt_d     = cnt_q;
            buf_d     = buf_q;
            err_d     = err_q;
            code_d    = code_q;
            // ERR already pulses the full clear on its own cycle
            clr_all_d = (state_q != S_ERR);
        end
    end

    // Output decodes of the registered state.
    always_comb begin
        desc_cs_o   = (state_q == S_FETCH);
        desc_addr_o = (state_q == S_FETCH) ? ptr_q : '0;
        eng_start_o = (state_q == S_ISSUE) ? oh_id[N_ENG-1:0] : '0;
        if ((state_q == S_ERR) || clr_all_q) begin
            eng_clr_o = '1;
        end else if (state_q == S_NEXT) begin
            eng_clr_o = oh_id[N_ENG-1:0];
        end else begin
            eng_clr_o = '0;
        end
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        buf_sel_o   = buf_q;
        err_o       = err_q;
        err_code_o  = code_q;
        layer_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_epu_layer_seq.sv
// Bench for epu_layer_seq: descriptor SRAM and engine models, scoreboard of
// expected engine starts and buffer flips, directed list scenarios.
module tb_epu_layer_seq;

    localparam int N_ENG = 3;
    localparam int MAXL  = 4;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic             cmd_start;
    logic [9:0]       cmd_base;
    logic             abort;
    logic             desc_cs;
    logic [9:0]       desc_addr;
    logic [31:0]      desc_rdata;
    logic [N_ENG-1:0] eng_start;
    logic [N_ENG-1:0] eng_finish;
    logic [N_ENG-1:0] eng_clr;
    logic             buf_sel, busy, done, err;
    logic [1:0]       err_code;
    logic [6:0]       layer_cnt;

    always #5 clk = ~clk;

    epu_layer_seq #(.N_ENG(N_ENG), .MAX_LAYERS(MAXL), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rstn(rstn), .cmd_start_i(cmd_start), .cmd_base_i(cmd_base),
        .abort_i(abort), .desc_cs_o(desc_cs), .desc_addr_o(desc_addr),
        .desc_rdata_i(desc_rdata), .eng_start_o(eng_start), .eng_finish_i(eng_finish),
        .eng_clr_o(eng_clr), .buf_sel_o(buf_sel), .busy_o(busy), .done_o(done),
        .err_o(err), .err_code_o(err_code), .layer_cnt_o(layer_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Descriptor SRAM, one-cycle read latency
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (desc_cs) desc_rdata <= mem[desc_addr];
    end

    // Engine models: finish after cfg_delay cycles (0 = never), held for
    // cfg_hold cycles after a clear
    int cfg_delay, cfg_hold;
    int run [N_ENG];
    int hold [N_ENG];
    always @(posedge clk) begin
        if (!rstn) begin
            eng_finish <= '0;
            for (int e = 0; e < N_ENG; e++) begin
                run[e]  <= 0;
                hold[e] <= 0;
            end
        end else begin
            for (int e = 0; e < N_ENG; e++) begin
                if (eng_start[e]) begin
                    run[e] <= cfg_delay;
                end else if (eng_clr[e]) begin
                    run[e] <= 0;
                    if (cfg_hold == 0) eng_finish[e] <= 1'b0;
                    else hold[e] <= cfg_hold;
                end else begin
                    if (run[e] > 0) begin
                        if (run[e] == 1) eng_finish[e] <= 1'b1;
                        run[e] <= run[e] - 1;
                    end
                    if (hold[e] > 0) begin
                        if (hold[e] == 1) eng_finish[e] <= 1'b0;
                        hold[e] <= hold[e] - 1;
                    end
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and event recorder
    int exp_start_q[$];
    bit exp_buf_q[$];
    int start_cyc_q[$];
    int clr_cyc_q[$];
    int n_start, n_done, n_clr_all, first_start_cyc, clr_all_cyc;
    int err_rise_cyc, busy_fall_cyc, start_cyc, mon_id;
    logic [N_ENG-1:0] start_prev = '0;
    logic done_prev = 1'b0, buf_prev = 1'b0, err_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (eng_start != '0) begin
                n_start++;
                start_cyc_q.push_back(cyc);
                if (first_start_cyc < 0) first_start_cyc = cyc;
                chk("start_while_finish", 32'(eng_start & eng_finish), 0);
                if (exp_start_q.size() == 0) begin
                    chk("unexpected_start", 32'(eng_start), 0);
                end else begin
                    mon_id = exp_start_q.pop_front();
                    chk("eng_start", 32'(eng_start), 32'(1 << mon_id));
                end
            end
            if ((eng_start & start_prev) != '0) chk("start_width", 32'(eng_start & start_prev), 0);
            if (done && done_prev) chk("done_width", 32'(done), 0);
            if (done) n_done++;
            if (eng_clr == '1) begin
                n_clr_all++;
                clr_all_cyc = cyc;
            end else if (eng_clr != '0) begin
                clr_cyc_q.push_back(cyc);
            end
            if (buf_sel != buf_prev) begin
                if (exp_buf_q.size() == 0) chk("unexpected_buf", 32'(buf_sel), 32'(buf_prev));
                else chk("buf_sel", 32'(buf_sel), 32'(exp_buf_q.pop_front()));
            end
            if (err && !err_prev) err_rise_cyc = cyc;
            if (!busy && busy_prev) busy_fall_cyc = cyc;
        end
        start_prev = eng_start;
        done_prev  = done;
        buf_prev   = buf_sel;
        err_prev   = err;
        busy_prev  = busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_start(input logic [9:0] base);
        tick();
        n_start = 0; n_done = 0; n_clr_all = 0;
        first_start_cyc = -1; clr_all_cyc = -1; err_rise_cyc = -1; busy_fall_cyc = -1;
        start_cyc_q.delete();
        clr_cyc_q.delete();
        cmd_base  = base;
        cmd_start = 1'b1;
        start_cyc = cyc;
        tick();
        cmd_start = 1'b0;
        chk("err_clear_on_start", 32'(err), 0);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int i = 0;
        while (busy && i < max) begin
            tick();
            i++;
        end
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic wait_starts(input int n, input int max);
        int i = 0;
        while (n_start < n && i < max) begin
            tick();
            i++;
        end
        chk("wait_starts", 32'(n_start >= n), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    int gap, clr_before;

    initial begin
        rstn = 1'b0; cmd_start = 1'b0; cmd_base = '0; abort = 1'b0;
        cfg_delay = 5; cfg_hold = 0;
        for (int a = 0; a < 1024; a++) mem[a] = 32'h0;

        // reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_layer_cnt", 32'(layer_cnt), 0);
        chk("rst_buf_sel", 32'(buf_sel), 0);
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_eng_clr", 32'(eng_clr), 0);
        chk("rst_desc_cs", 32'(desc_cs), 0);
        chk("rst_desc_addr", 32'(desc_addr), 0);
        rstn = 1'b1;
        tick();

        // three-layer list with buffer swaps
        mem[10'h010] = 32'h8; mem[10'h011] = 32'hA; mem[10'h012] = 32'h5;
        exp_start_q = '{0, 2, 1};
        exp_buf_q   = '{1'b1, 1'b0};
        run_start(10'h010);
        wait_idle("t1", 200);
        chk("t1_latency", 32'(first_start_cyc - start_cyc), 3);
        chk("t1_n_start", 32'(n_start), 3);
        chk("t1_layer_cnt", 32'(layer_cnt), 3);
        chk("t1_buf_sel", 32'(buf_sel), 0);
        chk("t1_done", 32'(n_done), 1);
        chk("t1_err", 32'(err), 0);
        chk("t1_buf_left", 32'(exp_buf_q.size()), 0);

        // same engine twice, finish lingers after the clear
        cfg_hold = 4;
        mem[10'h020] = 32'h1; mem[10'h021] = 32'h5;
        exp_start_q = '{1, 1};
        run_start(10'h020);
        wait_idle("t2", 200);
        gap = (start_cyc_q.size() >= 2 && clr_cyc_q.size() >= 1) ? start_cyc_q[1] - clr_cyc_q[0] : -1;
        chk("t2_restart_gap", 32'(gap), 6);
        chk("t2_n_start", 32'(n_start), 2);
        chk("t2_layer_cnt", 32'(layer_cnt), 2);
        chk("t2_done", 32'(n_done), 1);
        cfg_hold = 0;
        repeat (6) tick();

        // engine id out of range
        mem[10'h030] = 32'h3;
        run_start(10'h030);
        wait_idle("t3", 50);
        chk("t3_err", 32'(err), 1);
        chk("t3_err_code", 32'(err_code), 1);
        chk("t3_clr_all", 32'(n_clr_all), 1);
        chk("t3_clr_all_cyc", 32'(clr_all_cyc - start_cyc), 3);
        chk("t3_n_start", 32'(n_start), 0);
        chk("t3_done", 32'(n_done), 0);

        // watchdog timeout
        cfg_delay = 0;
        mem[10'h040] = 32'h6;
        exp_start_q = '{2};
        run_start(10'h040);
        wait_idle("t4", 100);
        chk("t4_err_code", 32'(err_code), 3);
        chk("t4_err", 32'(err), 1);
        chk("t4_timeout_cyc", 32'(err_rise_cyc - start_cyc_q[0]), 16);
        chk("t4_busy_fall", 32'(busy_fall_cyc - err_rise_cyc), 1);
        chk("t4_done", 32'(n_done), 0);
        chk("t4_clr_all", 32'(n_clr_all), 1);

        // list longer than MAX_LAYERS without a last flag
        cfg_delay = 3;
        mem[10'h050] = 32'h0; mem[10'h051] = 32'h1; mem[10'h052] = 32'h2;
        mem[10'h053] = 32'h0; mem[10'h054] = 32'h5;
        exp_start_q = '{0, 1, 2, 0};
        run_start(10'h050);
        wait_idle("t5", 200);
        chk("t5_err_code", 32'(err_code), 2);
        chk("t5_layer_cnt", 32'(layer_cnt), 4);
        chk("t5_n_start", 32'(n_start), 4);
        chk("t5_done", 32'(n_done), 0);

        // descriptor pointer wraps from 0x3FF to 0x000
        mem[10'h3FF] = 32'hA; mem[10'h000] = 32'h4;
        exp_start_q = '{2, 0};
        exp_buf_q   = '{1'b1};
        run_start(10'h3FF);
        wait_idle("t6", 200);
        chk("t6_done", 32'(n_done), 1);
        chk("t6_layer_cnt", 32'(layer_cnt), 2);
        chk("t6_buf_sel", 32'(buf_sel), 1);
        chk("t6_err_code", 32'(err_code), 0);

        // abort in WAIT of the second layer
        cfg_delay = 8;
        mem[10'h060] = 32'h9; mem[10'h061] = 32'h6;
        exp_start_q = '{1, 2};
        exp_buf_q   = '{1'b0, 1'b1};
        run_start(10'h060);
        wait_starts(2, 100);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t7_busy", 32'(busy), 0);
        chk("t7_eng_clr", 32'(eng_clr), 32'h7);
        chk("t7_layer_cnt", 32'(layer_cnt), 1);
        chk("t7_buf_sel", 32'(buf_sel), 1);
        chk("t7_err", 32'(err), 0);
        tick();
        chk("t7_eng_clr_after", 32'(eng_clr), 0);
        chk("t7_clr_all", 32'(n_clr_all), 1);
        chk("t7_done", 32'(n_done), 0);

        // reset in WAIT, then a normal run
        cfg_delay = 10;
        mem[10'h070] = 32'h8; mem[10'h071] = 32'h5;
        exp_start_q = '{0, 1};
        exp_buf_q   = '{1'b0, 1'b1};
        run_start(10'h070);
        wait_starts(2, 100);
        tick();
        clr_before = n_clr_all;
        rstn = 1'b0;
        #1;
        chk("t8_busy", 32'(busy), 0);
        chk("t8_buf_sel", 32'(buf_sel), 0);
        chk("t8_layer_cnt", 32'(layer_cnt), 0);
        chk("t8_eng_clr", 32'(eng_clr), 0);
        chk("t8_eng_start", 32'(eng_start), 0);
        chk("t8_desc_cs", 32'(desc_cs), 0);
        chk("t8_err", 32'(err), 0);
        tick();
        chk("t8_eng_clr_held", 32'(eng_clr), 0);
        rstn = 1'b1;
        tick();
        chk("t8_no_clr_all", 32'(n_clr_all - clr_before), 0);
        cfg_delay = 5;
        mem[10'h078] = 32'h6;
        exp_start_q = '{2};
        run_start(10'h078);
        wait_idle("t8b", 100);
        chk("t8b_latency", 32'(first_start_cyc - start_cyc), 3);
        chk("t8b_done", 32'(n_done), 1);
        chk("t8b_layer_cnt", 32'(layer_cnt), 1);
        chk("t8b_err", 32'(err), 0);

        chk("start_q_left", 32'(exp_start_q.size()), 0);
        chk("buf_q_left", 32'(exp_buf_q.size()), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
